unary_add_sched: RTL and testbench

Round-robin scheduler that shares one serial unary adder (A/B bitstream inputs, `en`, `read_or_write`, serial `dout`) among several requesters. It grants one requester at a time and clears the adder. It then sequences a fixed-length read phase, steering the winner's A/B bits into the adder, followed by a fixed-length write phase that returns the adder's `dout` stream to the winner. It sits between the requester ports and a single adder instance.

---
 rtl/unary_add_sched_pkg.sv | 23 ++
 rtl/unary_add_sched_rr_arbiter.sv | 49 ++++
 rtl/unary_add_sched.sv | 146 ++++++++++++++
 tb/tb_unary_add_sched.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/unary_add_sched_pkg.sv
// unary_add_sched shared types and helpers.
// FSM state encoding, adder mode constants, counter width.
package unary_add_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RD   = 2'd2,
    WR   = 2'd3
  } state_e;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } rw_e;

  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/unary_add_sched_rr_arbiter.sv
// Round-robin one-hot picker for unary_add_sched.
// Search starts at ptr; ptr moves past the winner on adv.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] pick_idx,
  output logic          any
);

  logic [IW-1:0] ptr;
  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // first requester at or after ptr, wrapping
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(N))
        sum = sum - (IW+1)'(N);
      idx = sum[IW-1:0];
      if (!any && req[idx]) begin
        any       = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = idx;
      end
    end
  end

  // pointer moves to winner+1 on each grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (adv)
      ptr <= (pick_idx == IW'(N-1)) ? '0
                                    : pick_idx + IW'(1);
  end

endmodule

// File: rtl/unary_add_sched.sv
// Round-robin scheduler sharing one serial unary adder.
// Optional abort on dropped request: UNARY_ADD_SCHED_ABORT_EN.
module unary_add_sched
  import unary_add_sched_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int STREAM_LEN = 19,
  parameter int WR_LEN     = 2*STREAM_LEN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_a,
  input  logic [N_REQ-1:0]         req_b,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic                     done,
  output logic                     abort,
  output logic                     add_rst_n,
  output logic                     add_en,
  output logic                     add_rw,
  output logic                     add_a,
  output logic                     add_b,
  input  logic                     add_dout,
  output logic                     rsp_valid,
  output logic                     rsp_dout,
  output logic [$clog2(N_REQ)-1:0] rsp_id
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = cnt_w(STREAM_LEN, WR_LEN);

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [N_REQ-1:0] pick;
  logic [IW-1:0]   pick_idx;
  logic            any;
  logic            grant;
  rw_e             rw;

  assign grant = (state == IDLE) && any;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .adv      (grant),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any)
  );

`ifdef UNARY_ADD_SCHED_ABORT_EN
  logic lost;
  logic abort_q;
  assign lost  = ~|(req & gnt);
  assign abort = abort_q;
`else
  assign abort = 1'b0;
`endif

  // job sequencer: grant, clear, read phase, write phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      gnt    <= '0;
      rsp_id <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef UNARY_ADD_SCHED_ABORT_EN
      abort_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef UNARY_ADD_SCHED_ABORT_EN
      abort_q <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (any) begin
            gnt    <= pick;
            rsp_id <= pick_idx;
            busy   <= 1'b1;
            state  <= CLR;
          end
        end
        CLR: begin
          cnt   <= CW'(STREAM_LEN-1);
          state <= RD;
        end
        RD: begin
`ifdef UNARY_ADD_SCHED_ABORT_EN
          if (lost) begin
            state   <= IDLE;
            gnt     <= '0;
            busy    <= 1'b0;
            abort_q <= 1'b1;
          end else
`endif
          if (cnt == '0) begin
            cnt   <= CW'(WR_LEN-1);
            state <= WR;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WR: begin
`ifdef UNARY_ADD_SCHED_ABORT_EN
          if (lost) begin
            state   <= IDLE;
            gnt     <= '0;
            busy    <= 1'b0;
            abort_q <= 1'b1;
          end else
`endif
          if (cnt == '0) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // adder controls decode straight from the state register
  always_comb begin
    rw        = (state == WR) ? WRITE : READ;
    add_rw    = rw;
    add_rst_n = (state != CLR);
    add_en    = (state == RD) || (state == WR);
    add_a     = (state == RD) && req_a[rsp_id];
    add_b     = (state == RD) && req_b[rsp_id];
    rsp_valid = (state == WR);
    rsp_dout  = (state == WR) && add_dout;
  end

endmodule

// File: tb/tb_unary_add_sched.sv
// Bench for unary_add_sched with a counting unary adder model.
// Abort steps are built only with UNARY_ADD_SCHED_ABORT_EN.
module tb_unary_add_sched;

  localparam int N  = 4;
  localparam int SL = 19;
  localparam int WL = 38;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, req_a, req_b, gnt;
  logic       busy, done, abort;
  logic       add_rst_n, add_en, add_rw;
  logic       add_a, add_b, add_dout;
  logic       rsp_valid, rsp_dout;
  logic [1:0] rsp_id;

  int n_assert = 0;
  int n_fail   = 0;
  int ptr_m    = 0;
  int acc      = 0;

  always #5 clk = ~clk;

  unary_add_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .abort     (abort),
    .add_rst_n (add_rst_n),
    .add_en    (add_en),
    .add_rw    (add_rw),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_dout  (add_dout),
    .rsp_valid (rsp_valid),
    .rsp_dout  (rsp_dout),
    .rsp_id    (rsp_id)
  );

  // unary adder: count ones while reading, emit them while writing
  always @(posedge clk) begin
    if (!add_rst_n)
      acc <= 0;
    else if (add_en && !add_rw)
      acc <= acc + int'(add_a) + int'(add_b);
    else if (add_en && add_rw && acc > 0)
      acc <= acc - 1;
  end
  assign add_dout = add_en && add_rw && (acc > 0);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic int pick_m(input logic [3:0] r);
    for (int i = 0; i < N; i++)
      if (r[(ptr_m + i) % N]) return (ptr_m + i) % N;
    return -1;
  endfunction

  task automatic chk_reset_vals();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_abort", 32'(abort), 0);
    chk("rst_add_rst_n", 32'(add_rst_n), 1);
    chk("rst_add_en", 32'(add_en), 0);
    chk("rst_add_rw", 32'(add_rw), 0);
    chk("rst_add_a", 32'(add_a), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
  endtask

  // one granted job; entered in the IDLE cycle that samples req
  task automatic run_job(input int id,
                         input logic [SL-1:0] a,
                         input logic [SL-1:0] b,
                         input bit rand_oth,
                         input int abort_at);
    int ones = 0;
    @(negedge clk); #1;
    chk("gnt", 32'(gnt), 32'(1 << id));
    chk("busy", 32'(busy), 1);
    chk("clr_rst_n", 32'(add_rst_n), 0);
    chk("clr_en", 32'(add_en), 0);
    chk("rsp_id", 32'(rsp_id), 32'(id));
    chk("clr_done", 32'(done), 0);
    for (int k = 0; k < SL; k++) begin
      @(negedge clk);
      req_a = 4'($urandom);
      req_b = 4'($urandom);
      req_a[id] = a[k];
      req_b[id] = b[k];
      if (rand_oth) req = 4'($urandom) | 4'(1 << id);
      #1;
      chk("rd_add_a", 32'(add_a), 32'(a[k]));
      chk("rd_add_b", 32'(add_b), 32'(b[k]));
      chk("rd_en", 32'(add_en), 1);
      chk("rd_rw", 32'(add_rw), 0);
      chk("rd_gnt", 32'(gnt), 32'(1 << id));
    end
    for (int j = 0; j < WL; j++) begin
      @(negedge clk);
      req_a = 4'($urandom);
      req_b = 4'($urandom);
      if (rand_oth) req = 4'($urandom) | 4'(1 << id);
      if (j == abort_at) req[id] = 1'b0;
      #1;
      chk("wr_en", 32'(add_en), 1);
      chk("wr_rw", 32'(add_rw), 1);
      chk("wr_add_a", 32'(add_a | add_b), 0);
      chk("wr_valid", 32'(rsp_valid), 1);
      chk("wr_rsp_id", 32'(rsp_id), 32'(id));
      if (rsp_dout) ones++;
      if (j == abort_at) begin
        @(negedge clk); #1;
        chk("ab_abort", 32'(abort), 1);
        chk("ab_busy", 32'(busy), 0);
        chk("ab_gnt", 32'(gnt), 0);
        chk("ab_done", 32'(done), 0);
        chk("ab_valid", 32'(rsp_valid), 0);
        return;
      end
    end
    @(negedge clk); #1;
    chk("done", 32'(done), 1);
    chk("end_busy", 32'(busy), 0);
    chk("end_gnt", 32'(gnt), 0);
    chk("end_abort", 32'(abort), 0);
    chk("end_en", 32'(add_en), 0);
    chk("ones", 32'(ones),
        32'($countones(a) + $countones(b)));
  endtask

  // model picks the winner from the current req and ptr
  task automatic go(input logic [SL-1:0] a,
                    input logic [SL-1:0] b,
                    input bit rand_oth,
                    input int abort_at);
    int e;
    e = pick_m(req);
    ptr_m = (e + 1) % N;
    run_job(e, a, b, rand_oth, abort_at);
  endtask

  initial begin
    int e;
    logic [SL-1:0] a;
    rst_n = 1'b0;
    req   = '0;
    req_a = '0;
    req_b = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals();
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("idle_gnt", 32'(gnt), 0);

    // round robin with all requesting: 0,1,2,3,0
    @(negedge clk);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      chk("rr_model", 32'(pick_m(req)), 32'(i % N));
      go(SL'($urandom), SL'($urandom), 1'b0, -1);
    end

    // single job, all-ones operands
    req = 4'b0100;
    go({SL{1'b1}}, {SL{1'b1}}, 1'b0, -1);

    // late request from 3 during a job for 0
    req = 4'b0001;
    go(SL'($urandom), SL'($urandom), 1'b1, -1);
    req = 4'b1000;
    go(SL'($urandom), SL'($urandom), 1'b0, -1);

    // data steering, A starts 1,1,0
    req = 4'b0010;
    a = SL'($urandom);
    a[2:0] = 3'b011;
    go(a, SL'($urandom), 1'b0, -1);

    // random request sets
    for (int i = 0; i < 4; i++) begin
      req = 4'($urandom_range(1, 15));
      go(SL'($urandom), SL'($urandom), 1'b1, -1);
    end

    // reset during RD cycle 7
    req = 4'b0010;
    e = pick_m(req);
    ptr_m = (e + 1) % N;
    @(negedge clk); #1;
    chk("pre_rst_gnt", 32'(gnt), 32'(1 << e));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req_a = 4'($urandom);
      req_b = 4'($urandom);
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    req = 4'b0110;
    ptr_m = 0;
    repeat (2) begin
      @(negedge clk); #1;
      chk("rst_hold_done", 32'(done), 0);
      chk("rst_hold_gnt", 32'(gnt), 0);
    end
    rst_n = 1'b1;
    chk("post_rst_pick", 32'(pick_m(req)), 1);
    go(SL'($urandom), SL'($urandom), 1'b0, -1);

`ifdef UNARY_ADD_SCHED_ABORT_EN
    req = 4'b0001;
    go(SL'($urandom), SL'($urandom), 1'b0, -1);
    req = 4'b0110;
    go(SL'($urandom), SL'($urandom), 1'b0, 5);
    chk("post_ab_pick", 32'(pick_m(req)), 2);
    go(SL'($urandom), SL'($urandom), 1'b0, -1);
`endif

    req = '0;
    @(negedge clk); #1;
    chk("final_idle", 32'(busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
